leve_fetch_queue: RTL and testbench

Instruction fetch queue feeding the decode stage of the LEVE pipeline. It generates AXI read address bursts from a running fetch PC and stores the returned instruction words in a FIFO. It presents one instruction per cycle with its PC on a valid/ready handshake. It also flushes and refetches when the execute stage signals a taken branch or jump (redirect).

---
 rtl/leve_fetch_queue.sv | 105 ++++++++++
 tb/tb_leve_fetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/leve_fetch_queue.sv
// leve_fetch_queue: AXI burst instruction fetcher with FIFO, decode handshake and redirect flush
module leve_fetch_queue #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int BURST_LEN = 8,
  parameter int DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [1:0]        ARBURST,
  output logic [7:0]        ARLEN,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [31:0]       RDATA,
  input  logic              RLAST,
  output logic              INST_VALID,
  input  logic              INST_READY,
  output logic [31:0]       INST,
  output logic [ADDR_W-1:0] INST_PC
);
  localparam int OW = $clog2(BURST_LEN);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t state_q, state_d;
  logic drop_q, drop_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d, araddr_q, araddr_d, redir_pc;
  logic [7:0] arlen_q, arlen_d;
  logic [PW:0] count_q, count_d;
  logic [PW-1:0] wr_q, rd_q;
  logic [31:0] mem_q [DEPTH];
  logic push, pop, last, room_now, room_next;
  assign redir_pc = REDIRECT_PC & ~ADDR_W'(3);
  assign ARVALID = state_q == ADDR;
  assign RREADY = state_q == DATA || state_q == DRAIN;
  assign ARADDR = araddr_q;
  assign ARLEN = arlen_q;
  assign ARBURST = 2'b01;
  assign INST_VALID = count_q != '0;
  assign INST = mem_q[rd_q];
  assign INST_PC = head_pc_q;
  assign last = RREADY && RVALID && RLAST;
  assign push = state_q == DATA && RVALID && !REDIRECT;
  assign pop = INST_VALID && INST_READY && !REDIRECT;
  assign count_d = REDIRECT ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  // a full burst of space is reserved up front so RREADY never drops mid-burst
  assign room_now = count_q <= (PW+1)'(DEPTH - BURST_LEN);
  assign room_next = count_d <= (PW+1)'(DEPTH - BURST_LEN);
  assign head_pc_d = REDIRECT ? redir_pc : pop ? head_pc_q + ADDR_W'(4) : head_pc_q;
  always_comb begin
    state_d = state_q;
    drop_d = drop_q;
    araddr_d = araddr_q;
    arlen_d = arlen_q;
    fetch_pc_d = REDIRECT ? redir_pc : fetch_pc_q;
    case (state_q)
      IDLE: state_d = (!REDIRECT && room_now) ? ADDR : IDLE;
      ADDR: begin
        // a redirect while the address is pending cannot retract it; its data is drained instead
        drop_d = ARREADY ? 1'b0 : drop_q || REDIRECT;
        if (ARREADY) begin
          state_d = (drop_q || REDIRECT) ? DRAIN : DATA;
          if (!drop_q && !REDIRECT) fetch_pc_d = fetch_pc_q + ADDR_W'({arlen_q, 2'b00}) + ADDR_W'(4);
        end
      end
      DATA: state_d = last ? ((!REDIRECT && room_next) ? ADDR : IDLE) : REDIRECT ? DRAIN : DATA;
      DRAIN: state_d = last ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (state_d == ADDR && state_q != ADDR) begin
      araddr_d = fetch_pc_q;
      arlen_d = 8'(BURST_LEN - 1) - 8'(fetch_pc_q[OW+1:2]);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      drop_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      head_pc_q <= RESET_PC;
      araddr_q <= RESET_PC;
      arlen_q <= '0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q <= head_pc_d;
      araddr_q <= araddr_d;
      arlen_q <= arlen_d;
      count_q <= count_d;
      wr_q <= REDIRECT ? '0 : wr_q + PW'(push);
      rd_q <= REDIRECT ? '0 : rd_q + PW'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= RDATA;
  end
endmodule

// File: tb/tb_leve_fetch_queue.sv
// tb_leve_fetch_queue: AXI slave plus flow-level reference model for the fetch queue
module tb_leve_fetch_queue;
  localparam int BL = 8;
  localparam int DEPTH = 16;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  logic CLK = 1'b0, RST = 1'b1, REDIRECT = 1'b0, ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0, INST_READY = 1'b0;
  logic [63:0] REDIRECT_PC = '0;
  logic [31:0] RDATA = '0;
  logic ARVALID, RREADY, INST_VALID;
  logic [63:0] ARADDR, INST_PC;
  logic [1:0] ARBURST;
  logic [7:0] ARLEN;
  logic [31:0] INST;
  int tests = 0, fails = 0;
  logic [63:0] q[$];
  logic [63:0] fresh_addr[$];
  logic [7:0] fresh_len[$];
  logic [63:0] fetch_ptr, b_addr, prev_addr, last_ar;
  logic [7:0] b_len, prev_len;
  int gen, pres_gen, b_gen, beat, ar_count, pops;
  int unsigned ar_pct = 100, r_pct = 100;
  bit busy, presenting, prev_stall, ar_hold;

  leve_fetch_queue dut (
    .CLK(CLK), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY), .INST(INST), .INST_PC(INST_PC)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mw(logic [63:0] a);
    return a[31:0] ^ 32'h5EED_0000;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REDIRECT = 1'b0;
    ARREADY = 1'b0;
    RVALID = 1'b0;
    RLAST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    q.delete();
    fresh_addr.delete();
    fresh_len.delete();
    fetch_ptr = RPC;
    busy = 0;
    presenting = 0;
    prev_stall = 0;
    gen = 0;
    ar_count = 0;
    pops = 0;
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_inst_valid", INST_VALID, 0);
    chk("rst_arlen", ARLEN, 0);
    chk("rst_araddr", ARADDR, RPC);
    chk("rst_inst_pc", INST_PC, RPC);
  endtask

  // one clock: drive the slave, check outputs against the model, advance the model across the edge
  task automatic cycle();
    bit was_busy;
    int off;
    ARREADY = !ar_hold && ($urandom_range(99) < ar_pct);
    if (busy && $urandom_range(99) < r_pct) begin
      RVALID = 1'b1;
      RDATA = mw(b_addr + 64'(beat * 4));
      RLAST = beat == int'(b_len);
    end else begin
      RVALID = 1'b0;
      RDATA = $urandom;
      RLAST = 1'($urandom_range(1));
    end
    #1;
    chk("arburst", ARBURST, 2'b01);
    chk("rready", RREADY, busy);
    chk("ar_outstanding", ARVALID && busy, 0);
    chk("inst_valid", INST_VALID, q.size() != 0);
    if (q.size() != 0) begin
      chk("inst_pc", INST_PC, q[0]);
      chk("inst", INST, mw(q[0]));
    end
    if (ARVALID && !presenting) begin
      presenting = 1;
      pres_gen = gen;
      chk("reserve", q.size() <= DEPTH - BL, 1);
    end
    if (prev_stall) begin
      chk("ar_hold_valid", ARVALID, 1);
      chk("ar_hold_addr", ARADDR, prev_addr);
      chk("ar_hold_len", ARLEN, prev_len);
    end
    was_busy = busy;
    if (INST_VALID && INST_READY && !REDIRECT && q.size() != 0) begin
      void'(q.pop_front());
      pops++;
    end
    if (RVALID && RREADY && busy) begin
      if (b_gen == gen && !REDIRECT) q.push_back(b_addr + 64'(beat * 4));
      if (beat == int'(b_len)) busy = 0;
      beat++;
      chk("depth", q.size() <= DEPTH, 1);
    end
    if (ARVALID && ARREADY && !was_busy) begin
      off = int'((fetch_ptr >> 2) % BL);
      if (pres_gen == gen) begin
        chk("araddr", ARADDR, fetch_ptr);
        chk("arlen", ARLEN, 64'(BL - 1 - off));
        fresh_addr.push_back(ARADDR);
        fresh_len.push_back(ARLEN);
        if (!REDIRECT) fetch_ptr = fetch_ptr + 64'(4 * (BL - off));
      end
      chk("ar_4k", (int'(ARADDR[11:0]) + (int'(ARLEN) + 1) * 4) <= 4096, 1);
      busy = 1;
      b_addr = ARADDR;
      b_len = ARLEN;
      b_gen = pres_gen;
      beat = 0;
      presenting = 0;
      ar_count++;
      last_ar = ARADDR;
    end
    prev_stall = ARVALID && !ARREADY;
    prev_addr = ARADDR;
    prev_len = ARLEN;
    if (REDIRECT) begin
      gen++;
      q.delete();
      fetch_ptr = REDIRECT_PC & ~64'h3;
      fresh_addr.delete();
      fresh_len.delete();
    end
    if (!ARVALID) presenting = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic redirect_to(logic [63:0] pc, logic rdy);
    REDIRECT = 1'b1;
    REDIRECT_PC = pc;
    INST_READY = rdy;
    cycle();
    REDIRECT = 1'b0;
  endtask

  initial begin
    // boot from reset with full-rate bus and decode
    INST_READY = 1'b1;
    do_reset();
    for (int i = 0; i < 100 && pops < 8; i++) cycle();
    chk("boot_pops", pops >= 8, 1);
    chk("boot_ars", fresh_addr.size() >= 2, 1);
    if (fresh_addr.size() >= 2) begin
      chk("boot_ar0", fresh_addr[0], RPC);
      chk("boot_len0", fresh_len[0], 7);
      chk("boot_ar1", fresh_addr[1], RPC + 64'h20);
    end
    // backpressure: two bursts fill the FIFO, then fetching stops
    INST_READY = 1'b0;
    do_reset();
    repeat (80) cycle();
    chk("bp_count", q.size(), 16);
    chk("bp_ars", ar_count, 2);
    chk("bp_arvalid", ARVALID, 0);
    INST_READY = 1'b1;
    repeat (8) cycle();
    INST_READY = 1'b0;
    for (int i = 0; i < 40 && ar_count < 3; i++) cycle();
    chk("bp_third", ar_count, 3);
    chk("bp_third_addr", last_ar, RPC + 64'h40);
    // unaligned redirect gives a truncated first burst
    redirect_to(64'h8000_1014, 1'b1);
    for (int i = 0; i < 100 && fresh_addr.size() < 2; i++) cycle();
    chk("unal_ars", fresh_addr.size() >= 2, 1);
    if (fresh_addr.size() >= 2) begin
      chk("unal_ar0", fresh_addr[0], 64'h8000_1014);
      chk("unal_len0", fresh_len[0], 2);
      chk("unal_ar1", fresh_addr[1], 64'h8000_1020);
      chk("unal_len1", fresh_len[1], 7);
    end
    // redirect on beat 3 of a full burst
    for (int i = 0; i < 200 && !(busy && b_gen == gen && b_len == 8'd7 && beat == 3); i++) cycle();
    chk("mid_found", busy && beat == 3, 1);
    redirect_to(64'h8000_2000, 1'b1);
    for (int i = 0; i < 100 && fresh_addr.size() < 1; i++) cycle();
    chk("mid_ar", fresh_addr.size() >= 1 ? fresh_addr[0] : 64'h0, 64'h8000_2000);
    // redirect while the address channel is stalled
    ar_hold = 1;
    for (int i = 0; i < 100 && !ARVALID; i++) cycle();
    chk("stall_found", ARVALID, 1);
    cycle();
    redirect_to(64'h8000_3008, 1'b1);
    repeat (3) cycle();
    ar_hold = 0;
    for (int i = 0; i < 100 && fresh_addr.size() < 1; i++) cycle();
    chk("stall_ar", fresh_addr.size() >= 1 ? fresh_addr[0] : 64'h0, 64'h8000_3008);
    chk("stall_len", fresh_len.size() >= 1 ? 64'(fresh_len[0]) : 64'hFF, 5);
    // redirect coinciding with a pop and the last beat
    INST_READY = 1'b0;
    for (int i = 0; i < 200 && !(busy && b_gen == gen && beat == int'(b_len) && INST_VALID); i++) cycle();
    chk("rl_found", busy && INST_VALID, 1);
    redirect_to(64'h8000_4000, 1'b1);
    INST_READY = 1'b0;
    chk("rl_inst_valid", INST_VALID, 0);
    chk("rl_idle_arvalid", ARVALID, 0);
    chk("rl_idle_rready", RREADY, 0);
    cycle();
    chk("rl_arvalid", ARVALID, 1);
    chk("rl_araddr", ARADDR, 64'h8000_4000);
    chk("rl_arlen", ARLEN, 7);
    // randomized traffic with random redirects
    pops = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        ar_pct = $urandom_range(30, 100);
        r_pct = $urandom_range(30, 100);
      end
      REDIRECT = $urandom_range(99) < 2;
      REDIRECT_PC = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFF)};
      INST_READY = 1'($urandom_range(1));
      cycle();
    end
    REDIRECT = 1'b0;
    chk("rand_progress", pops > 200, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
